// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA host interface: FSM encoding, operand select codes
// and default widths.
package rsa_pkg;

    localparam int unsigned WORD_W_DEF = 32;
    localparam int unsigned KEY_W_DEF  = 2048;

    typedef enum logic [1:0] {
        StIdle,
        StKick,
        StWait,
        StDone
    } rsa_state_e;

    localparam logic [1:0] SEL_C   = 2'd0;
    localparam logic [1:0] SEL_E   = 2'd1;
    localparam logic [1:0] SEL_N   = 2'd2;
    localparam logic [1:0] SEL_CLR = 2'd3;

endpackage

// File: rtl/rsa_word_buf.sv
// NW x WORD_W register file: indexed word write, parallel load, full-width view and
// indexed word read.
module rsa_word_buf #(
    parameter int unsigned NW     = 64,
    parameter int unsigned WORD_W = 32,
    parameter int unsigned AW     = 6
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 we_i,
    input  logic [AW-1:0]        waddr_i,
    input  logic [WORD_W-1:0]    wdata_i,
    input  logic                 load_i,
    input  logic [NW*WORD_W-1:0] load_data_i,
    input  logic [AW-1:0]        raddr_i,
    output logic [NW*WORD_W-1:0] q_o,
    output logic [WORD_W-1:0]    rdata_o
);

    logic [WORD_W-1:0] mem_q [NW];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NW); i++) begin
                mem_q[i] <= '0;
            end
        end else if (load_i) begin
            for (int i = 0; i < int'(NW); i++) begin
                mem_q[i] <= load_data_i[i*WORD_W +: WORD_W];
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    for (genvar g = 0; g < NW; g++) begin : g_flat
        assign q_o[g*WORD_W +: WORD_W] = mem_q[g];
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rsa_host_if.sv
// Host-side wrapper for a modular-exponentiation engine: word-wise operand loading,
// start/finish handshake with watchdog, and word-wise result readout.
module rsa_host_if
    import rsa_pkg::*;
#(
    parameter int unsigned WORD_W    = WORD_W_DEF,
    parameter int unsigned KEY_W     = KEY_W_DEF,
    parameter int unsigned START_CYC = 2,
    parameter int unsigned TIMEOUT   = 2**24
) (
    input  logic              clk,
    input  logic              sys_rst_n,
    input  logic              wr_en,
    input  logic [1:0]        wr_sel,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              go,
    input  logic              rd_en,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [KEY_W-1:0]  exp_c,
    output logic [KEY_W-1:0]  exp_e,
    output logic [KEY_W-1:0]  exp_n,
    output logic              exp_start,
    input  logic              exp_finish,
    input  logic [KEY_W-1:0]  exp_result
);

    localparam int unsigned NW  = KEY_W / WORD_W;
    localparam int unsigned PW  = (NW > 1) ? $clog2(NW) : 1;
    localparam int unsigned SCW = (START_CYC > 1) ? $clog2(START_CYC) : 1;
    localparam int unsigned WDW = $clog2(TIMEOUT + 1);

    localparam logic [PW-1:0]  PtrLast  = PW'(NW - 1);
    localparam logic [SCW-1:0] KickLast = SCW'(START_CYC - 1);
    localparam logic [WDW-1:0] WdLast   = WDW'(TIMEOUT - 1);

    rsa_state_e        state_q;
    logic [PW-1:0]     c_ptr_q, e_ptr_q, n_ptr_q, rd_ptr_q;
    logic [SCW-1:0]    kick_cnt_q;
    logic [WDW-1:0]    wdog_q;
    logic              busy_q, done_q, err_q, exp_start_q, rd_valid_q;
    logic [WORD_W-1:0] rd_data_q;

    logic              idle_or_done, wr_ok, res_load;
    logic [WORD_W-1:0] res_word;
    logic [WORD_W-1:0] c_rd_unused, e_rd_unused, n_rd_unused;
    logic [KEY_W-1:0]  res_full_unused;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PtrLast) ? '0 : p + PW'(1);
    endfunction

    // Busy states lock the operand registers so the engine sees stable inputs.
    assign idle_or_done = (state_q == StIdle) || (state_q == StDone);
    assign wr_ok        = wr_en && idle_or_done;
    assign res_load     = (state_q == StWait) && exp_finish;

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= StIdle;
            c_ptr_q     <= '0;
            e_ptr_q     <= '0;
            n_ptr_q     <= '0;
            rd_ptr_q    <= '0;
            kick_cnt_q  <= '0;
            wdog_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            exp_start_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            rd_valid_q <= 1'b0;
            if (wr_ok) begin
                case (wr_sel)
                    SEL_C:   c_ptr_q <= ptr_inc(c_ptr_q);
                    SEL_E:   e_ptr_q <= ptr_inc(e_ptr_q);
                    SEL_N:   n_ptr_q <= ptr_inc(n_ptr_q);
                    default: begin
                        c_ptr_q <= '0;
                        e_ptr_q <= '0;
                        n_ptr_q <= '0;
                    end
                endcase
            end
            unique case (state_q)
                StIdle, StDone: begin
                    // go takes priority over a simultaneous read.
                    if (go) begin
                        state_q     <= StKick;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        err_q       <= 1'b0;
                        exp_start_q <= 1'b1;
                        kick_cnt_q  <= '0;
                        wdog_q      <= '0;
                        rd_ptr_q    <= '0;
                    end else if (rd_en && (state_q == StDone)) begin
                        rd_data_q  <= res_word;
                        rd_valid_q <= 1'b1;
                        rd_ptr_q   <= ptr_inc(rd_ptr_q);
                    end
                end
                StKick: begin
                    if (kick_cnt_q == KickLast) begin
                        state_q     <= StWait;
                        exp_start_q <= 1'b0;
                    end else begin
                        kick_cnt_q <= kick_cnt_q + SCW'(1);
                    end
                end
                StWait: begin
                    if (exp_finish) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (wdog_q == WdLast) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                    end else begin
                        wdog_q <= wdog_q + WDW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    rsa_word_buf #(.NW(NW), .WORD_W(WORD_W), .AW(PW)) u_buf_c (
        .clk_i       (clk),
        .rst_ni      (sys_rst_n),
        .we_i        (wr_ok && (wr_sel == SEL_C)),
        .waddr_i     (c_ptr_q),
        .wdata_i     (wr_data),
        .load_i      (1'b0),
        .load_data_i ('0),
        .raddr_i     ('0),
        .q_o         (exp_c),
        .rdata_o     (c_rd_unused)
    );

    rsa_word_buf #(.NW(NW), .WORD_W(WORD_W), .AW(PW)) u_buf_e (
        .clk_i       (clk),
        .rst_ni      (sys_rst_n),
        .we_i        (wr_ok && (wr_sel == SEL_E)),
        .waddr_i     (e_ptr_q),
        .wdata_i     (wr_data),
        .load_i      (1'b0),
        .load_data_i ('0),
        .raddr_i     ('0),
        .q_o         (exp_e),
        .rdata_o     (e_rd_unused)
    );

    rsa_word_buf #(.NW(NW), .WORD_W(WORD_W), .AW(PW)) u_buf_n (
        .clk_i       (clk),
        .rst_ni      (sys_rst_n),
        .we_i        (wr_ok && (wr_sel == SEL_N)),
        .waddr_i     (n_ptr_q),
        .wdata_i     (wr_data),
        .load_i      (1'b0),
        .load_data_i ('0),
        .raddr_i     ('0),
        .q_o         (exp_n),
        .rdata_o     (n_rd_unused)
    );

    rsa_word_buf #(.NW(NW), .WORD_W(WORD_W), .AW(PW)) u_buf_res (
        .clk_i       (clk),
        .rst_ni      (sys_rst_n),
        .we_i        (1'b0),
        .waddr_i     ('0),
        .wdata_i     ('0),
        .load_i      (res_load),
        .load_data_i (exp_result),
        .raddr_i     (rd_ptr_q),
        .q_o         (res_full_unused),
        .rdata_o     (res_word)
    );

    logic unused_bits;
    assign unused_bits = ^{c_rd_unused, e_rd_unused, n_rd_unused, res_full_unused};

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign exp_start = exp_start_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;

endmodule
